scroll_executor: RTL and testbench

- Responder for the cursor block's scroll requests: consumes `scrollReady` plus the scroll fields (dir, step, top, bottom).
- Executes the request on the text RAM: copies lines within the scroll region by `step` lines, then blanks the vacated lines.
- Sits between the parser's cursor logic and the character buffer.
- Holds one pending request so a new request arriving while busy is not lost.

---
 rtl/scroll_executor.sv | 209 ++++++++++++++++++++
 tb/tb_scroll_executor.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scroll_executor.sv
// Scroll engine: copies text lines inside a region by a step and then blanks the vacated lines.
// Latency 2 + 2*C*COLUMNS + S*COLUMNS cycles; one request is buffered while busy, and any further request is dropped with an overflow pulse.
module scroll_executor #(
    parameter int              LINES      = 24,
    parameter int              COLUMNS    = 80,
    parameter int              DATA_W     = 16,
    parameter int              ADDR_W     = 12,
    parameter logic [DATA_W-1:0] BLANK_WORD = 16'h0020
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scroll_req,
    input  logic              scroll_dir,
    input  logic [7:0]        scroll_step,
    input  logic [7:0]        scroll_top,
    input  logic [7:0]        scroll_bottom,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int                COL_W    = $clog2(COLUMNS);
    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(COLUMNS - 1);
    localparam logic [ADDR_W-1:0] COL_STEP = ADDR_W'(COLUMNS);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_RD, S_WR, S_CLR, S_FIN} state_t;

    typedef struct packed {
        logic       dir;
        logic [7:0] step;
        logic [7:0] top;
        logic [7:0] bottom;
    } req_t;

    state_t            state_q, state_d;
    req_t              cur_q, cur_d, pend_q, pend_d, req_in;
    logic              pend_vld_q, pend_vld_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [7:0]        copy_left_q, copy_left_d;
    logic [7:0]        clr_left_q, clr_left_d;
    logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d, clr_q, clr_d;
    logic              busy_q, busy_d, done_q, done_d;

    logic [7:0] height, eff_step, copy_lines;
    logic       invalid;

    function automatic logic [ADDR_W-1:0] line_base(input logic [7:0] line);
        return ADDR_W'(line) * COL_STEP;
    endfunction

    assign req_in     = '{dir: scroll_dir, step: scroll_step, top: scroll_top, bottom: scroll_bottom};
    assign height     = cur_q.bottom - cur_q.top + 8'd1;
    assign eff_step   = (cur_q.step == 8'd0) ? 8'd1 : ((cur_q.step > height) ? height : cur_q.step);
    assign copy_lines = height - eff_step;
    assign invalid    = (cur_q.top > cur_q.bottom) || (cur_q.bottom >= 8'(LINES));

    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        pend_d      = pend_q;
        pend_vld_d  = pend_vld_q;
        col_d       = col_q;
        copy_left_d = copy_left_q;
        clr_left_d  = clr_left_q;
        src_d       = src_q;
        dst_d       = dst_q;
        clr_d       = clr_q;
        overflow    = 1'b0;

        // A request landing while the slot drains in IDLE refills the slot.
        if (state_q == S_IDLE) begin
            if (pend_vld_q) begin
                cur_d      = pend_q;
                pend_vld_d = scroll_req;
                if (scroll_req) begin
                    pend_d = req_in;
                end
                state_d = S_SETUP;
            end else if (scroll_req) begin
                cur_d   = req_in;
                state_d = S_SETUP;
            end
        end else if (scroll_req) begin
            if (!pend_vld_q) begin
                pend_d     = req_in;
                pend_vld_d = 1'b1;
            end else begin
                overflow = rst;
            end
        end

        case (state_q)
            S_SETUP: begin
                col_d       = '0;
                copy_left_d = copy_lines;
                clr_left_d  = eff_step;
                if (!cur_q.dir) begin
                    dst_d = line_base(cur_q.top);
                    src_d = line_base(cur_q.top + eff_step);
                    clr_d = line_base(cur_q.bottom - eff_step + 8'd1);
                end else begin
                    dst_d = line_base(cur_q.bottom);
                    src_d = line_base(cur_q.bottom - eff_step);
                    clr_d = line_base(cur_q.top);
                end
                if (invalid) begin
                    state_d = S_FIN;
                end else if (copy_lines == 8'd0) begin
                    state_d = S_CLR;
                end else begin
                    state_d = S_RD;
                end
            end
            S_RD: state_d = S_WR;
            S_WR: begin
                if (col_q == COL_LAST) begin
                    col_d       = '0;
                    copy_left_d = copy_left_q - 8'd1;
                    src_d       = cur_q.dir ? (src_q - COL_STEP) : (src_q + COL_STEP);
                    dst_d       = cur_q.dir ? (dst_q - COL_STEP) : (dst_q + COL_STEP);
                    state_d     = (copy_left_q == 8'd1) ? S_CLR : S_RD;
                end else begin
                    col_d   = col_q + 1'b1;
                    state_d = S_RD;
                end
            end
            S_CLR: begin
                if (col_q == COL_LAST) begin
                    col_d      = '0;
                    clr_left_d = clr_left_q - 8'd1;
                    clr_d      = clr_q + COL_STEP;
                    state_d    = (clr_left_q == 8'd1) ? S_FIN : S_CLR;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: ;
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_FIN);
    end

    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        case (state_q)
            S_RD: begin
                ram_en   = 1'b1;
                ram_addr = src_q + ADDR_W'(col_q);
            end
            S_WR: begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = dst_q + ADDR_W'(col_q);
                ram_wdata = ram_rdata;
            end
            S_CLR: begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = clr_q + ADDR_W'(col_q);
                ram_wdata = BLANK_WORD;
            end
            default: ;
        endcase
    end

    assign busy = busy_q;
    assign done = done_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cur_q       <= '0;
            pend_q      <= '0;
            pend_vld_q  <= 1'b0;
            col_q       <= '0;
            copy_left_q <= '0;
            clr_left_q  <= '0;
            src_q       <= '0;
            dst_q       <= '0;
            clr_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            pend_q      <= pend_d;
            pend_vld_q  <= pend_vld_d;
            col_q       <= col_d;
            copy_left_q <= copy_left_d;
            clr_left_q  <= clr_left_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            clr_q       <= clr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_scroll_executor.sv
// Bench for scroll_executor: a RAM model plus a line-level reference of the scroll result and its latency.
module tb_scroll_executor;

    localparam int LINES   = 24;
    localparam int COLUMNS = 80;
    localparam int ADDR_W  = 12;
    localparam int MEM_N   = 1 << ADDR_W;
    localparam logic [15:0] BLANK = 16'h0020;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              scroll_req = 1'b0;
    logic              scroll_dir = 1'b0;
    logic [7:0]        scroll_step = '0;
    logic [7:0]        scroll_top = '0;
    logic [7:0]        scroll_bottom = '0;
    logic              busy, done, overflow, ram_en, ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [15:0]       ram_wdata;
    logic [15:0]       ram_rdata;

    logic [15:0] mem      [MEM_N];
    logic [15:0] init_img [MEM_N];
    logic [15:0] exp_img  [MEM_N];
    logic        load_img = 1'b0;
    int          cyc = 0;
    int          en_cnt = 0;
    int          wr_cnt = 0;
    int          checks = 0;
    int          failures = 0;
    logic        ovf_last;

    scroll_executor dut (
        .clk(clk), .rst(rst), .scroll_req(scroll_req), .scroll_dir(scroll_dir),
        .scroll_step(scroll_step), .scroll_top(scroll_top), .scroll_bottom(scroll_bottom),
        .busy(busy), .done(done), .overflow(overflow), .ram_en(ram_en), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (load_img) begin
            for (int i = 0; i < MEM_N; i++) mem[i] <= init_img[i];
        end else if (ram_en) begin
            en_cnt <= en_cnt + 1;
            if (ram_we) begin
                mem[ram_addr] <= ram_wdata;
                wr_cnt        <= wr_cnt + 1;
            end else begin
                ram_rdata <= mem[ram_addr];
            end
        end
    end

    task automatic align;
        @(posedge clk); #1;
    endtask

    task automatic goto_cycle(input int target);
        while (cyc < target) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic drive_req(input logic d, input int st, input int tp, input int bt);
        scroll_dir    = d;
        scroll_step   = 8'(st);
        scroll_top    = 8'(tp);
        scroll_bottom = 8'(bt);
        scroll_req    = 1'b1;
        @(negedge clk);
        ovf_last = overflow;
        @(posedge clk); #1;
        scroll_req = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int at);
        int n;
        at = -1;
        n  = 0;
        while (at < 0 && n < budget) begin
            @(negedge clk);
            if (done === 1'b1) at = cyc;
            n++;
        end
    endtask

    task automatic snapshot;
        for (int i = 0; i < MEM_N; i++) exp_img[i] = mem[i];
    endtask

    task automatic fill(input bit rnd);
        for (int i = 0; i < MEM_N; i++) begin
            if (i >= LINES * COLUMNS) init_img[i] = 16'hBEEF;
            else if (rnd)             init_img[i] = 16'($urandom);
            else                      init_img[i] = 16'((i / COLUMNS) * 256 + (i % COLUMNS));
        end
        load_img = 1'b1;
        @(posedge clk); #1;
        load_img = 1'b0;
        snapshot();
    endtask

    // Line-level view of a scroll: each line is either unchanged, a copy of line l+-S, or blank.
    task automatic model(input logic d, input int st, input int tp, input int bt);
        logic [15:0] old [MEM_N];
        int h, s, src;
        if (tp > bt || bt >= LINES) return;
        for (int i = 0; i < MEM_N; i++) old[i] = exp_img[i];
        h = bt - tp + 1;
        s = (st == 0) ? 1 : ((st > h) ? h : st);
        for (int l = tp; l <= bt; l++) begin
            if (!d) src = (l + s <= bt) ? l + s : -1;
            else    src = (l - s >= tp) ? l - s : -1;
            for (int c = 0; c < COLUMNS; c++)
                exp_img[l * COLUMNS + c] = (src < 0) ? BLANK : old[src * COLUMNS + c];
        end
    endtask

    function automatic int exp_lat(input int st, input int tp, input int bt);
        int h, s;
        if (tp > bt || bt >= LINES) return 2;
        h = bt - tp + 1;
        s = (st == 0) ? 1 : ((st > h) ? h : st);
        return 2 + 2 * (h - s) * COLUMNS + s * COLUMNS;
    endfunction

    task automatic compare_ram(output int nd, output int first);
        nd    = 0;
        first = -1;
        for (int i = 0; i < MEM_N; i++) begin
            if (mem[i] !== exp_img[i]) begin
                if (first < 0) first = i;
                nd++;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        checks++; if (ram_en !== 1'b0) begin failures++; $display("FAIL reset_ram_en: got %b want 0", ram_en); end
        checks++; if (ram_we !== 1'b0) begin failures++; $display("FAIL reset_ram_we: got %b want 0", ram_we); end
        checks++; if (ram_addr !== '0) begin failures++; $display("FAIL reset_ram_addr: got %0h want 0", ram_addr); end
        checks++; if (ram_wdata !== '0) begin failures++; $display("FAIL reset_ram_wdata: got %0h want 0", ram_wdata); end
        align();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_scroll_up_full;
        int t, at, nd, first;
        fill(1'b0);
        model(1'b0, 1, 0, 23);
        align();
        t = cyc;
        drive_req(1'b0, 1, 0, 23);
        wait_done(5000, at);
        checks++; if (at - t !== 3762) begin failures++; $display("FAIL up_full_latency: got %0d want 3762", at - t); end
        compare_ram(nd, first);
        checks++; if (nd !== 0) begin failures++; $display("FAIL up_full_ram: %0d bad words, first at %0d got %0h want %0h", nd, first, mem[first], exp_img[first]); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL up_full_busy_after: got %b want 0", busy); end
    endtask

    task automatic test_scroll_down;
        int t, at, nd, first;
        fill(1'b0);
        model(1'b1, 2, 5, 10);
        align();
        t = cyc;
        drive_req(1'b1, 2, 5, 10);
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL down_busy: got %b want 1", busy); end
        wait_done(2000, at);
        checks++; if (at - t !== 802) begin failures++; $display("FAIL down_latency: got %0d want 802", at - t); end
        compare_ram(nd, first);
        checks++; if (nd !== 0) begin failures++; $display("FAIL down_ram: %0d bad words, first at %0d got %0h want %0h", nd, first, mem[first], exp_img[first]); end
    endtask

    task automatic test_step_clamp;
        int t, at, nd, first;
        fill(1'b1);
        model(1'b0, 1, 3, 6);
        align();
        t = cyc;
        drive_req(1'b0, 0, 3, 6);
        wait_done(2000, at);
        checks++; if (at - t !== 562) begin failures++; $display("FAIL step0_latency: got %0d want 562", at - t); end
        compare_ram(nd, first);
        checks++; if (nd !== 0) begin failures++; $display("FAIL step0_ram: %0d bad words, first at %0d", nd, first); end
        model(1'b1, 4, 3, 6);
        align();
        t = cyc;
        drive_req(1'b1, 50, 3, 6);
        wait_done(2000, at);
        checks++; if (at - t !== 322) begin failures++; $display("FAIL step50_latency: got %0d want 322", at - t); end
        compare_ram(nd, first);
        checks++; if (nd !== 0) begin failures++; $display("FAIL step50_ram: %0d bad words, first at %0d", nd, first); end
    endtask

    task automatic test_back_to_back;
        int t, at1, at2, nd, first, busy_cnt;
        fill(1'b1);
        model(1'b0, 1, 0, 3);
        model(1'b1, 2, 10, 15);
        align();
        t = cyc;
        drive_req(1'b0, 1, 0, 3);
        goto_cycle(t + 5);
        drive_req(1'b1, 2, 10, 15);
        checks++; if (ovf_last !== 1'b0) begin failures++; $display("FAIL b2b_second_overflow: got %b want 0", ovf_last); end
        goto_cycle(t + 9);
        drive_req(1'b0, 5, 18, 23);
        checks++; if (ovf_last !== 1'b1) begin failures++; $display("FAIL b2b_third_overflow: got %b want 1", ovf_last); end
        @(negedge clk);
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL b2b_overflow_pulse: got %b want 0", overflow); end
        wait_done(2000, at1);
        checks++; if (at1 - t !== 562) begin failures++; $display("FAIL b2b_first_latency: got %0d want 562", at1 - t); end
        wait_done(2000, at2);
        checks++; if (at2 - at1 !== 803) begin failures++; $display("FAIL b2b_second_start: got %0d want 803", at2 - at1); end
        busy_cnt = 0;
        repeat (60) begin
            @(negedge clk);
            if (busy === 1'b1) busy_cnt++;
        end
        checks++; if (busy_cnt !== 0) begin failures++; $display("FAIL b2b_third_ran: busy cycles %0d want 0", busy_cnt); end
        compare_ram(nd, first);
        checks++; if (nd !== 0) begin failures++; $display("FAIL b2b_ram: %0d bad words, first at %0d", nd, first); end
    endtask

    task automatic test_invalid;
        int t, at, e0, nd, first;
        fill(1'b1);
        e0 = en_cnt;
        align();
        t = cyc;
        drive_req(1'b0, 1, 10, 4);
        wait_done(20, at);
        checks++; if (at - t !== 2) begin failures++; $display("FAIL inv_topbot_latency: got %0d want 2", at - t); end
        checks++; if (en_cnt !== e0) begin failures++; $display("FAIL inv_topbot_ram_en: got %0d accesses want 0", en_cnt - e0); end
        align();
        t = cyc;
        drive_req(1'b1, 1, 0, 24);
        wait_done(20, at);
        checks++; if (at - t !== 2) begin failures++; $display("FAIL inv_bottom_latency: got %0d want 2", at - t); end
        checks++; if (en_cnt !== e0) begin failures++; $display("FAIL inv_bottom_ram_en: got %0d accesses want 0", en_cnt - e0); end
        compare_ram(nd, first);
        checks++; if (nd !== 0) begin failures++; $display("FAIL inv_ram: %0d bad words, first at %0d", nd, first); end
    endtask

    task automatic test_reset_abort;
        int t, at, w0, busy_cnt, nd, first;
        fill(1'b0);
        align();
        t = cyc;
        drive_req(1'b0, 1, 0, 23);
        goto_cycle(t + 3);
        drive_req(1'b1, 1, 0, 23);
        goto_cycle(t + 1000);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        w0 = wr_cnt;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy: got %b want 0", busy); end
        checks++; if (ram_en !== 1'b0) begin failures++; $display("FAIL abort_ram_en: got %b want 0", ram_en); end
        busy_cnt = 0;
        repeat (30) begin
            @(negedge clk);
            if (busy === 1'b1) busy_cnt++;
        end
        checks++; if (busy_cnt !== 0) begin failures++; $display("FAIL abort_pending: busy cycles %0d want 0", busy_cnt); end
        checks++; if (wr_cnt !== w0) begin failures++; $display("FAIL abort_writes: got %0d writes want 0", wr_cnt - w0); end
        snapshot();
        model(1'b1, 3, 2, 20);
        align();
        t = cyc;
        drive_req(1'b1, 3, 2, 20);
        wait_done(5000, at);
        checks++; if (at - t !== 2802) begin failures++; $display("FAIL abort_rerun_latency: got %0d want 2802", at - t); end
        compare_ram(nd, first);
        checks++; if (nd !== 0) begin failures++; $display("FAIL abort_rerun_ram: %0d bad words, first at %0d", nd, first); end
    endtask

    task automatic test_random;
        int t, at, nd, first, tp, bt, st;
        logic d;
        fill(1'b1);
        for (int k = 0; k < 6; k++) begin
            d  = 1'($urandom_range(0, 1));
            tp = $urandom_range(0, LINES - 1);
            bt = $urandom_range(tp, LINES - 1);
            st = $urandom_range(0, bt - tp + 3);
            if ($urandom_range(0, 4) == 0) begin
                if ($urandom_range(0, 1) == 1) bt = $urandom_range(LINES, 40);
                else if (tp > 0) bt = $urandom_range(0, tp - 1);
            end
            model(d, st, tp, bt);
            align();
            t = cyc;
            drive_req(d, st, tp, bt);
            wait_done(5000, at);
            checks++; if (at - t !== exp_lat(st, tp, bt)) begin failures++; $display("FAIL rand%0d_latency: got %0d want %0d (dir %0d step %0d top %0d bottom %0d)", k, at - t, exp_lat(st, tp, bt), d, st, tp, bt); end
            compare_ram(nd, first);
            checks++; if (nd !== 0) begin failures++; $display("FAIL rand%0d_ram: %0d bad words, first at %0d (dir %0d step %0d top %0d bottom %0d)", k, nd, first, d, st, tp, bt); end
        end
    endtask

    initial begin
        test_reset();
        test_scroll_up_full();
        test_scroll_down();
        test_step_clamp();
        test_back_to_back();
        test_invalid();
        test_reset_abort();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
